// File: rtl/key_word_transform_pkg.sv
// rtl/key_word_transform_pkg.sv - shared encodings, key-size tables and GF(2^8) helpers for the key word transform
package key_word_transform_pkg;

    typedef enum logic [1:0] {
        MODE_128  = 2'b00,
        MODE_192  = 2'b01,
        MODE_256  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        XF_ROTSUB = 2'd0,
        XF_SUB    = 2'd1,
        XF_PASS   = 2'd2
    } xform_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int LAST_IDX_128 = 43;
    localparam int LAST_IDX_192 = 51;
    localparam int LAST_IDX_256 = 59;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input mode_e m);
        case (m)
            MODE_192: nk_of = 4'd6;
            MODE_256: nk_of = 4'd8;
            default:  nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input mode_e m);
        case (m)
            MODE_192: nr_of = 4'd12;
            MODE_256: nr_of = 4'd14;
            default:  nr_of = 4'd10;
        endcase
    endfunction

    // Index of the final word, 4*(Nr+1)-1.
    function automatic int last_idx_of(input mode_e m);
        case (m)
            MODE_192: last_idx_of = LAST_IDX_192;
            MODE_256: last_idx_of = LAST_IDX_256;
            default:  last_idx_of = LAST_IDX_128;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/generic_init_mem_2r.sv
// rtl/generic_init_mem_2r.sv - two-read-port ROM with enable-gated registered outputs
module generic_init_mem_2r #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = "sbox.init"
) (
    input  logic              clk_in,
    input  logic              en_in,
    input  logic [ADDR_W-1:0] addr_a_in,
    input  logic [ADDR_W-1:0] addr_b_in,
    output logic [DATA_W-1:0] rdata_a_out,
    output logic [DATA_W-1:0] rdata_b_out
);

    // The named image is built in as constant logic; unknown names give an identity ROM.
    localparam bit IS_SBOX = (INIT_FILE == "sbox.init");

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) inv = gf_mul(inv, sq);
            sq = gf_mul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [DATA_W-1:0] image(input logic [ADDR_W-1:0] a);
        if (IS_SBOX) return DATA_W'(aes_sbox(8'(a)));
        return DATA_W'(a);
    endfunction

    always_ff @(posedge clk_in) begin
        if (en_in) begin
            rdata_a_out <= image(addr_a_in);
            rdata_b_out <= image(addr_b_in);
        end
    end

endmodule

// File: rtl/key_word_transform.sv
// rtl/key_word_transform.sv - streaming AES key-expansion temp-word transform with index and Rcon tracking
module key_word_transform
    import key_word_transform_pkg::*;
#(
    parameter int OUT_REG   = 0,
    parameter int IDX_W     = 6,
    parameter     INIT_FILE = "sbox.init"
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [1:0]       conf_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      data_out,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy_out,
    output logic             err_out
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       phase_q, phase_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             err_q, err_d;

    logic             s1_valid_q, s1_valid_d;
    xform_e           s1_kind_q, s1_kind_d;
    logic [7:0]       s1_rcon_q, s1_rcon_d;
    logic [31:0]      s1_word_q, s1_word_d;
    logic [IDX_W-1:0] s1_index_q, s1_index_d;
    logic             s1_last_q, s1_last_d;

    logic             s1_free;
    logic             s2_valid;
    logic             accept;
    logic             is_last;
    logic [3:0]       nk;
    xform_e           kind;
    logic [7:0]       sb0, sb1, sb2, sb3;
    logic [31:0]      s1_result;

    assign nk       = nk_of(mode_q);
    assign in_ready = (state_q == ST_RUN) && (!s1_valid_q || s1_free);
    assign accept   = in_valid && in_ready && !start_in;
    assign is_last  = (idx_q == IDX_W'(last_idx_of(mode_q)));
    assign busy_out = (state_q != ST_IDLE);
    assign err_out  = err_q;

    always_comb begin
        kind = XF_PASS;
        if (phase_q == 3'd0)                               kind = XF_ROTSUB;
        else if (mode_q == MODE_256 && phase_q == 3'd4)   kind = XF_SUB;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        rcon_d     = rcon_q;
        err_d      = err_q;
        s1_valid_d = s1_valid_q;
        s1_kind_d  = s1_kind_q;
        s1_rcon_d  = s1_rcon_q;
        s1_word_d  = s1_word_q;
        s1_index_d = s1_index_q;
        s1_last_d  = s1_last_q;
        if (start_in) begin
            s1_valid_d = 1'b0;
            if (conf_in != 2'b11) begin
                state_d = ST_RUN;
                mode_d  = mode_e'(conf_in);
                idx_d   = IDX_W'(nk_of(mode_e'(conf_in)));
                phase_d = 3'd0;
                rcon_d  = RCON_INIT;
                err_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_kind_d  = kind;
                s1_rcon_d  = rcon_q;
                s1_word_d  = data_in;
                s1_index_d = idx_q;
                s1_last_d  = is_last;
                idx_d      = idx_q + IDX_W'(1);
                phase_d    = (phase_q == 3'(nk - 4'd1)) ? 3'd0 : phase_q + 3'd1;
                if (kind == XF_ROTSUB) rcon_d = xtime(rcon_q);
                if (is_last) state_d = ST_DRAIN;
            end else if (s1_free) begin
                s1_valid_d = 1'b0;
            end
            if (state_q == ST_DRAIN && !s1_valid_q && !s2_valid) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_128;
            idx_q      <= '0;
            phase_q    <= 3'd0;
            rcon_q     <= RCON_INIT;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_kind_q  <= XF_PASS;
            s1_rcon_q  <= 8'h00;
            s1_word_q  <= 32'h0;
            s1_index_q <= '0;
            s1_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            rcon_q     <= rcon_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            s1_kind_q  <= s1_kind_d;
            s1_rcon_q  <= s1_rcon_d;
            s1_word_q  <= s1_word_d;
            s1_index_q <= s1_index_d;
            s1_last_q  <= s1_last_d;
        end
    end

    // ROM reads only on accept, so the S-box bytes stay aligned with stage 1 while stalled.
    generic_init_mem_2r #(.DATA_W(8), .ADDR_W(8), .INIT_FILE(INIT_FILE)) u_sbox_lo (
        .clk_in      (clk_in),
        .en_in       (accept),
        .addr_a_in   (data_in[31:24]),
        .addr_b_in   (data_in[23:16]),
        .rdata_a_out (sb0),
        .rdata_b_out (sb1)
    );

    generic_init_mem_2r #(.DATA_W(8), .ADDR_W(8), .INIT_FILE(INIT_FILE)) u_sbox_hi (
        .clk_in      (clk_in),
        .en_in       (accept),
        .addr_a_in   (data_in[15:8]),
        .addr_b_in   (data_in[7:0]),
        .rdata_a_out (sb2),
        .rdata_b_out (sb3)
    );

    always_comb begin
        case (s1_kind_q)
            XF_ROTSUB: s1_result = {sb1 ^ s1_rcon_q, sb2, sb3, sb0};
            XF_SUB:    s1_result = {sb0, sb1, sb2, sb3};
            default:   s1_result = s1_word_q;
        endcase
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic             s2_valid_q, s2_valid_d;
        logic [31:0]      s2_data_q, s2_data_d;
        logic [IDX_W-1:0] s2_index_q, s2_index_d;
        logic             s2_last_q, s2_last_d;

        always_comb begin
            s2_valid_d = s2_valid_q;
            s2_data_d  = s2_data_q;
            s2_index_d = s2_index_q;
            s2_last_d  = s2_last_q;
            if (start_in) begin
                s2_valid_d = 1'b0;
            end else if (!s2_valid_q || out_ready) begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_result;
                s2_index_d = s1_index_q;
                s2_last_d  = s1_last_q;
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= 32'h0;
                s2_index_q <= '0;
                s2_last_q  <= 1'b0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
                s2_index_q <= s2_index_d;
                s2_last_q  <= s2_last_d;
            end
        end

        assign s2_valid  = s2_valid_q;
        assign s1_free   = !s2_valid_q || out_ready;
        assign out_valid = s2_valid_q;
        assign data_out  = s2_valid_q ? s2_data_q  : 32'h0;
        assign out_index = s2_valid_q ? s2_index_q : '0;
        assign out_last  = s2_valid_q && s2_last_q;
    end else begin : g_no_out_reg
        assign s2_valid  = 1'b0;
        assign s1_free   = out_ready;
        assign out_valid = s1_valid_q;
        assign data_out  = s1_valid_q ? s1_result  : 32'h0;
        assign out_index = s1_valid_q ? s1_index_q : '0;
        assign out_last  = s1_valid_q && s1_last_q;
    end

endmodule
